// File: rtl/expr_pkg.sv
// Shared constants and state type for the expression-string generator and checker benches.
package expr_pkg;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_PLUS = 8'h2B;
  localparam logic [7:0] ASCII_MUL  = 8'h2A;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIGIT,
    S_OP,
    S_DONE
  } state_e;

endpackage

// File: rtl/expr_char_enc.sv
// Combinational encoder: a BCD digit or an operator bit to its ASCII character.
module expr_char_enc
  import expr_pkg::*;
(
  input  logic       is_op,
  input  logic [3:0] digit,
  input  logic       op,
  output logic [7:0] ascii
);

  always_comb begin
    if (is_op) begin
      ascii = (op == OP_MUL) ? ASCII_MUL : ASCII_PLUS;
    end else begin
      ascii = ASCII_0 + {4'h0, digit};
    end
  end

endmodule

// File: rtl/expr_string_gen.sv
// Serializes a latched operand/operator snapshot as an ASCII "d(op d)*" stream over valid/ready.
module expr_string_gen
  import expr_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 4,
  parameter int unsigned TW        = $clog2(MAX_TERMS + 1)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [TW-1:0]          terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  input  logic                   out_ready,
  output logic [7:0]             out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_e                 state_q, state_d;
  logic [TW-1:0]          idx_q, idx_d;
  logic [TW-1:0]          terms_q, terms_d;
  logic [4*MAX_TERMS-1:0] digits_q, digits_d;
  logic [MAX_TERMS-2:0]   ops_q, ops_d;
  logic                   err_q, err_d;

  logic       bad_digit;
  logic       req_ok;
  logic [3:0] cur_digit;
  logic       cur_op;
  logic [7:0] ascii;

  // Only the digits that will actually be emitted are range-checked.
  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned k = 0; k < MAX_TERMS; k++) begin
      if ((TW'(k) < terms) && (digits[4*k +: 4] > 4'd9)) begin
        bad_digit = 1'b1;
      end
    end
  end

  assign req_ok = (terms != '0) && (terms <= TW'(MAX_TERMS)) && !bad_digit;

  always_comb begin
    cur_digit = 4'h0;
    cur_op    = OP_ADD;
    for (int unsigned k = 0; k < MAX_TERMS; k++) begin
      if (idx_q == TW'(k)) cur_digit = digits_q[4*k +: 4];
    end
    for (int unsigned k = 0; k < MAX_TERMS - 1; k++) begin
      if (idx_q == TW'(k)) cur_op = ops_q[k];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    terms_d  = terms_q;
    digits_d = digits_q;
    ops_d    = ops_q;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!req_ok) begin
            err_d = 1'b1;
          end else begin
            terms_d  = terms;
            digits_d = digits;
            ops_d    = ops;
            idx_d    = '0;
            state_d  = S_DIGIT;
          end
        end
      end
      S_DIGIT: begin
        if (out_ready) begin
          state_d = (idx_q == terms_q - TW'(1)) ? S_DONE : S_OP;
        end
      end
      S_OP: begin
        if (out_ready) begin
          idx_d   = idx_q + TW'(1);
          state_d = S_DIGIT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      terms_q  <= '0;
      digits_q <= '0;
      ops_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      terms_q  <= terms_d;
      digits_q <= digits_d;
      ops_q    <= ops_d;
      err_q    <= err_d;
    end
  end

  expr_char_enc u_enc (
    .is_op (state_q == S_OP),
    .digit (cur_digit),
    .op    (cur_op),
    .ascii (ascii)
  );

  // Outputs decode straight from state so a clr abort clears them without waiting for an edge.
  assign out_valid = (state_q == S_DIGIT) || (state_q == S_OP);
  assign out       = out_valid ? ascii : 8'h00;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_expr_string_gen.sv
// Self-checking bench for expr_string_gen: table vectors, hand sequences, random vs. a string model.
module tb_expr_string_gen;

  localparam int unsigned MAX_TERMS = 4;
  localparam int unsigned TW        = 3;

  logic                   clk = 1'b0;
  logic                   clr;
  logic                   start;
  logic [TW-1:0]          terms;
  logic [4*MAX_TERMS-1:0] digits;
  logic [MAX_TERMS-2:0]   ops;
  logic                   out_ready;
  logic [7:0]             out;
  logic                   out_valid;
  logic                   busy;
  logic                   done;
  logic                   err;

  expr_string_gen #(
    .MAX_TERMS (MAX_TERMS),
    .TW        (TW)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .terms     (terms),
    .digits    (digits),
    .ops       (ops),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  terms;
    logic [15:0] digits;
    logic [2:0]  ops;
    string       s;        // expected character stream
    bit          rej;      // request must be rejected
    int          mode;     // 0: ready always, 1: 1,0,0,1 pattern, 2: random
    bit          disturb;  // re-assert start with new inputs mid-string
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  vec_t        vec[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: the string a request should produce, or rejection.
  function automatic bit model(input int t, input logic [15:0] d, input logic [2:0] o);
    exp_q.delete();
    if (t < 1 || t > int'(MAX_TERMS)) return 1'b1;
    for (int k = 0; k < t; k++) if (d[4*k +: 4] > 4'd9) return 1'b1;
    for (int k = 0; k < t; k++) begin
      exp_q.push_back(8'h30 + 8'(d[4*k +: 4]));
      if (k < t - 1) exp_q.push_back(o[k] ? 8'h2A : 8'h2B);
    end
    return 1'b0;
  endfunction

  // Called at posedge+1; returns at posedge+1 with the DUT back in idle.
  task automatic run(input logic [2:0] t, input logic [15:0] d, input logic [2:0] o,
                     input bit rej, input int mode, input bit disturb);
    int pos;
    int cyc;
    int busy_cnt;
    bit rdy;
    terms = t; digits = d; ops = o; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    if (rej) begin
      check("err_pulse", 32'(err), 32'd1);
      check("rej_no_valid", 32'(out_valid), 32'd0);
      check("rej_no_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("err_one_cycle", 32'(err), 32'd0);
      check("rej_no_valid2", 32'(out_valid), 32'd0);
      return;
    end
    pos = 0; cyc = 0; busy_cnt = 0;
    while (pos < exp_q.size() && cyc < 200) begin
      check("valid", 32'(out_valid), 32'd1);
      check($sformatf("char%0d", pos), 32'(out), 32'(exp_q[pos]));
      check("busy_str", 32'(busy), 32'd1);
      check("no_err_str", 32'(err), 32'd0);
      check("no_done_str", 32'(done), 32'd0);
      busy_cnt++;
      if (disturb && cyc == 1) begin
        start = 1'b1; terms = 3'($urandom); digits = 16'($urandom); ops = 3'($urandom);
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
      out_ready = rdy;
      @(posedge clk); #1;
      if (rdy) pos++;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (cyc >= 200) check("string_timeout", 32'(pos), 32'(exp_q.size()));
    check("done_pulse", 32'(done), 32'd1);
    check("done_no_valid", 32'(out_valid), 32'd0);
    check("done_out_zero", 32'(out), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    busy_cnt++;
    if (mode == 0) check("busy_cycles", 32'(busy_cnt), 32'(2 * int'(t)));
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec[0] = '{3'd3, 16'h0321, 3'b010, "1+2*3",   1'b0, 0, 1'b0};
    vec[1] = '{3'd1, 16'hFFF7, 3'b111, "7",       1'b0, 0, 1'b0};
    vec[2] = '{3'd3, 16'h0321, 3'b010, "1+2*3",   1'b0, 1, 1'b0};
    vec[3] = '{3'd0, 16'h0321, 3'b000, "",        1'b1, 0, 1'b0};
    vec[4] = '{3'd2, 16'h00A5, 3'b000, "",        1'b1, 0, 1'b0};
    vec[5] = '{3'd5, 16'h1111, 3'b000, "",        1'b1, 0, 1'b0};
    vec[6] = '{3'd4, 16'h9087, 3'b111, "7*8*0*9", 1'b0, 0, 1'b0};
    vec[7] = '{3'd2, 16'hFF12, 3'b001, "2*1",     1'b0, 2, 1'b0};
    vec[8] = '{3'd3, 16'h0321, 3'b010, "1+2*3",   1'b0, 0, 1'b1};

    clr = 1'b1; start = 1'b0; terms = '0; digits = '0; ops = '0; out_ready = 1'b0;
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk); @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;

    foreach (vec[i]) begin
      exp_q.delete();
      for (int c = 0; c < vec[i].s.len(); c++) exp_q.push_back(8'(vec[i].s[c]));
      run(vec[i].terms, vec[i].digits, vec[i].ops, vec[i].rej, vec[i].mode, vec[i].disturb);
    end

    // Abort with clr after two characters have been accepted.
    terms = 3'd3; digits = 16'h0321; ops = 3'b010; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_clr_char", 32'(out), 32'h32);
    #2 clr = 1'b1;
    #1;
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_out", 32'(out), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("post_clr_done", 32'(done), 32'd0);
    check("post_clr_busy", 32'(busy), 32'd0);
    void'(model(2, 16'h0054, 3'b000));
    run(3'd2, 16'h0054, 3'b000, 1'b0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [2:0]  t;
      logic [15:0] d;
      logic [2:0]  o;
      bit          rej;
      t = 3'($urandom_range(0, 6));
      for (int k = 0; k < 4; k++)
        d[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      o = 3'($urandom);
      rej = model(int'(t), d, o);
      run(t, d, o, rej, 2, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
